// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   - lsu_state_e : FSM states of mem_stage_lsu
//   - lsu_size_e  : access size decoded from funct3
//   - BE_*        : byte-enable patterns for a lane-0 access
//   - decode_size : funct3 -> lsu_size_e ([1] word, else [0] half, else byte)
package rv32_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic lsu_size_e decode_size(input logic [2:0] funct3);
        if (funct3[1])      return LSU_WORD;
        else if (funct3[0]) return LSU_HALF;
        else                return LSU_BYTE;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering for the load/store unit.
//   size       in  2   access size (lsu_size_e encoding)
//   zext       in  1   1 = zero-extend loads, 0 = sign-extend
//   offset     in  2   byte offset of the address within the word
//   store_data in  32  right-aligned store data
//   read_data  in  32  raw word from the data bus
//   be         out 4   byte enables for a store of this size/offset
//   wdata      out 32  store data replicated across all lanes
//   load_data  out 32  selected, truncated and extended load data
//   misalign   out 1   half with offset[0]=1, or word with offset!=0
// Half accesses always use lane {offset[1],0} and word accesses lane 0, so
// the unaligned address bits are simply ignored when no trap is taken.
module lsu_lane_align
    import rv32_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case can leave a signal unassigned and infer a latch.
        lane     = 2'b00;
        be       = BE_WORD;
        wdata    = store_data;
        misalign = 1'b0;
        case (lsu_size_e'(size))
            LSU_BYTE: begin
                lane  = offset;
                be    = BE_BYTE << offset;
                wdata = {4{store_data[7:0]}};
            end
            LSU_HALF: begin
                lane     = {offset[1], 1'b0};
                be       = BE_HALF << {offset[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                misalign = offset[0];
            end
            default: begin
                misalign = |offset;
            end
        endcase
    end

    assign shifted = read_data >> {lane, 3'b000};

    always_comb begin
        load_data = shifted;
        case (lsu_size_e'(size))
            LSU_BYTE: load_data = {{24{~zext & shifted[7]}},  shifted[7:0]};
            LSU_HALF: load_data = {{16{~zext & shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit of the RV32I pipeline.
// Runs one req/gnt(/rvalid) transaction per load or store and stalls the
// upstream pipeline registers while the access is outstanding.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to suppress misaligned
// half/word accesses and pulse MisalignM instead; otherwise MisalignM is 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   MemReadM/MemWriteM  load / store request (store wins if both high)
//   StrobeM[2:0]        funct3: size in [1:0], [2]=1 zero-extends loads
//   isPeripheralM       region select, forwarded to bus_periph
//   ALUResultM          byte address
//   WriteDataM          right-aligned store data
//   StallM              freeze IF..EX/MEM while an access is in flight
//   ReadDataM           extended load data, non-zero only in DONE
//   ErrM                bus error pulse in DONE
//   MisalignM           misalignment pulse (trap build only)
//   bus_*               request/grant/response data bus master port
module mem_stage_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        StrobeM,
    input  logic              isPeripheralM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              ErrM,
    output logic              MisalignM,
    output logic              bus_req,
    output logic              bus_we,
    output logic              bus_periph,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    lsu_state_e  state_q, state_d;

    logic        we_q;
    logic        periph_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]  be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [1:0]  off_q;
    logic [DATA_W-1:0] rdata_q;
    logic        err_q;

    logic        in_idle;
    logic        access;
    logic        trap;
    logic        start;
    logic [1:0]  cur_size;
    logic [1:0]  align_size;
    logic        align_zext;
    logic [1:0]  align_off;
    logic [3:0]  align_be;
    logic [DATA_W-1:0] align_wdata;
    logic [DATA_W-1:0] align_load;
    logic        align_misalign;

    assign in_idle  = (state_q == ST_IDLE);
    assign access   = MemReadM | MemWriteM;
    assign cur_size = decode_size(StrobeM);

    // In IDLE the aligner decodes the incoming instruction so the store
    // lanes can be captured; afterwards it works from the captured fields
    // so the returning read data is extended with the right size/offset.
    assign align_size = in_idle ? cur_size       : size_q;
    assign align_zext = in_idle ? StrobeM[2]     : zext_q;
    assign align_off  = in_idle ? ALUResultM[1:0] : off_q;

    lsu_lane_align u_align (
        .size       (align_size),
        .zext       (align_zext),
        .offset     (align_off),
        .store_data (WriteDataM),
        .read_data  (bus_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap      = align_misalign;
    assign MisalignM = in_idle & access & align_misalign;
`else
    logic unused_misalign;
    assign unused_misalign = align_misalign;
    assign trap      = 1'b0;
    assign MisalignM = 1'b0;
`endif

    assign start = in_idle & access & ~trap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (bus_gnt) state_d = we_q ? ST_DONE : ST_RESP;
            ST_RESP: if (bus_rvalid) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the captured bus fields are reset as well, because every
            // bus_* output is driven straight from them and must read 0.
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            periph_q <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            zext_q   <= 1'b0;
            off_q    <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        we_q     <= MemWriteM;
                        periph_q <= isPeripheralM;
                        addr_q   <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        be_q     <= MemWriteM ? align_be : BE_WORD;
                        wdata_q  <= align_wdata;
                        size_q   <= cur_size;
                        zext_q   <= StrobeM[2];
                        off_q    <= ALUResultM[1:0];
                    end
                end
                ST_REQ: begin
                    // Writes complete on grant; the error travels with gnt.
                    if (bus_gnt && we_q) begin
                        err_q   <= bus_err;
                        rdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    if (bus_rvalid) begin
                        rdata_q <= align_load;
                        err_q   <= bus_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // The first stall cycle is combinational so the instruction in M is held
    // on the very edge that launches the request.
    assign StallM     = start | (state_q == ST_REQ) | (state_q == ST_RESP);
    assign bus_req    = (state_q == ST_REQ);
    assign bus_we     = we_q;
    assign bus_periph = periph_q;
    assign bus_addr   = addr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;
    assign ReadDataM  = ((state_q == ST_DONE) && !err_q) ? rdata_q : '0;
    assign ErrM       = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu. Stimulus pushes the
// expected bus request, the bus response to play back and the expected
// MEM/WB result; a bus responder and a monitor consume them independently.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, isPeripheralM;
    logic [2:0]  StrobeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, ErrM, MisalignM;
    logic [31:0] ReadDataM;
    logic        bus_req, bus_we, bus_periph;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid, bus_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemReadM      (MemReadM),
        .MemWriteM     (MemWriteM),
        .StrobeM       (StrobeM),
        .isPeripheralM (isPeripheralM),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .StallM        (StallM),
        .ReadDataM     (ReadDataM),
        .ErrM          (ErrM),
        .MisalignM     (MisalignM),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_periph    (bus_periph),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        periph;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          gd;
        int          rv;
    } rsp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } res_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    res_t res_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a, input logic we);
        int n = nbytes(f3);
        int o = int'(a % 4);
        if (!we || n == 4) return 4'b1111;
        if (n == 1) return 4'(1 << o);
        return (o >= 2) ? 4'b1100 : 4'b0011;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = nbytes(f3);
        if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(f3);
        int k;
        longint unsigned v, lim;
        k = (n == 1) ? int'(a % 4) : (n == 2) ? (int'(a % 4) & 2) : 0;
        v = rd >> (8 * k);
        if (n < 4) begin
            lim = 64'd1 << (8 * n);
            v = v % lim;
            if (!f3[2] && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        end
        return v[31:0];
    endfunction

    // ---------------- stimulus: one access to completion ----------------
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic periph,
                             input logic [31:0] rdata, input logic err, input int gd, input int rv);
        logic trap = 1'b0;
        int   exp_stall = 0;
        int   n = 0;
        bit   done = 0;
        bit   first = 1;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = model_misaligned(f3, a);
`endif
        if (!trap) begin
            req_q.push_back('{addr: {a[31:2], 2'b00}, we: wr, be: model_be(f3, a, wr),
                              wdata: model_wdata(f3, wd), periph: periph});
            rsp_q.push_back('{rdata: rdata, err: err, gd: gd, rv: rv});
            res_q.push_back('{data: (wr || err) ? 32'h0 : model_load(f3, a, rdata), err: err});
            exp_stall = 1 + (gd + 1) + (wr ? 0 : rv + 1);
        end
        MemReadM = rd; MemWriteM = wr; StrobeM = f3; ALUResultM = a;
        WriteDataM = wd; isPeripheralM = periph;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (first) begin
                check("misalign_flag", MisalignM, trap);
                if (trap) check("trap_no_req", bus_req, 1'b0);
                first = 0;
            end
            if (StallM) n++;
            else done = 1;
        end
        if (!done) check("complete_timeout", 0, 1);
        check("stall_cycles", n, exp_stall);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    // ---------------- bus responder ----------------
    initial begin
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        forever begin
            @(negedge clk);
            // Noise on rvalid/err/rdata outside RESP must be ignored.
            bus_gnt    = 1'b0;
            bus_rvalid = ($urandom_range(0, 3) == 0);
            bus_err    = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            if (bus_req && !rst) begin
                rsp_t s;
                if (rsp_q.size() == 0) begin
                    check("rsp_available", 0, 1);
                    s = '{rdata: 32'h0, err: 1'b0, gd: 0, rv: 0};
                end else begin
                    s = rsp_q.pop_front();
                end
                repeat (s.gd) @(negedge clk);
                bus_gnt = 1'b1;
                bus_err = bus_we ? s.err : 1'($urandom_range(0, 1));
                if (!bus_we) begin
                    @(negedge clk);
                    bus_gnt = 1'b0; bus_err = 1'b0; bus_rvalid = 1'b0;
                    repeat (s.rv) @(negedge clk);
                    bus_rvalid = 1'b1; bus_rdata = s.rdata; bus_err = s.err;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_stall = 1'b0;
    logic prev_req   = 1'b0;
    req_t cur;
    res_t r;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (prev_stall && !StallM) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("done_rdata", ReadDataM, r.data);
                    check("done_err", ErrM, r.err);
                end
            end else begin
                check("idle_rdata_zero", ReadDataM, 32'h0);
                check("idle_err_zero", ErrM, 1'b0);
            end
            if (bus_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    cur = req_q.pop_front();
                    check("req_addr", bus_addr, cur.addr);
                    check("req_we", bus_we, cur.we);
                    check("req_be", bus_be, cur.be);
                    check("req_periph", bus_periph, cur.periph);
                    if (cur.we) check("req_wdata", bus_wdata, cur.wdata);
                end
            end else if (bus_req) begin
                check("req_addr_stable", bus_addr, cur.addr);
                check("req_be_stable", bus_be, cur.be);
            end
            prev_stall = StallM;
            prev_req   = bus_req;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] load_f3  [5];
        logic [2:0] store_f3 [3];
        logic       seen;
        logic       found;
        load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_f3 = '{3'b000, 3'b001, 3'b010};

        rst = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; StrobeM = 3'b000; isPeripheralM = 1'b0;
        ALUResultM = '0; WriteDataM = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {StallM, ErrM, MisalignM, bus_req, bus_we, bus_periph, bus_be}, 10'h0);
        check("reset_rdata", ReadDataM, 32'h0);
        check("reset_addr", bus_addr, 32'h0);
        check("reset_wdata", bus_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SB 0xA5 @0x1002, grant two cycles after req
        do_access(0, 1, 3'b000, 32'h1002, 32'h0000_00A5, 0, 32'h0, 0, 2, 0);
        // LB / LBU @0x2003
        do_access(1, 0, 3'b000, 32'h2003, 32'h0, 0, 32'h80FF_FFFF, 0, 0, 0);
        do_access(1, 0, 3'b100, 32'h2003, 32'h0, 1, 32'h80FF_FFFF, 0, 1, 2);
        // LH / LHU @0x2002
        do_access(1, 0, 3'b001, 32'h2002, 32'h0, 0, 32'h8001_1234, 0, 0, 1);
        do_access(1, 0, 3'b101, 32'h2002, 32'h0, 0, 32'h8001_1234, 0, 2, 0);
        // misaligned LW @0x2001
        do_access(1, 0, 3'b010, 32'h2001, 32'h0, 0, 32'h1234_5678, 0, 0, 0);
        // misaligned SH @0x1003
        do_access(0, 1, 3'b001, 32'h1003, 32'hCAFE_BEEF, 1, 32'h0, 0, 1, 0);
        // read error, write error
        do_access(1, 0, 3'b010, 32'h3000, 32'h0, 0, 32'hDEAD_BEEF, 1, 0, 0);
        do_access(0, 1, 3'b010, 32'h3004, 32'h1122_3344, 1, 32'h0, 1, 0, 0);
        // read and write together: the write wins
        do_access(1, 1, 3'b010, 32'h3008, 32'h5566_7788, 0, 32'hFFFF_FFFF, 0, 1, 1);

        // reset while waiting in RESP; the late rvalid must be ignored
        req_q.push_back('{addr: 32'h4000, we: 1'b0, be: 4'b1111, wdata: 32'h0, periph: 1'b1});
        rsp_q.push_back('{rdata: 32'h1111_1111, err: 1'b0, gd: 0, rv: 4});
        MemReadM = 1'b1; StrobeM = 3'b010; ALUResultM = 32'h4000; isPeripheralM = 1'b1;
        seen = 1'b0; found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
            else if (seen && StallM) found = 1'b1;
        end
        if (!found) check("reach_resp", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1; MemReadM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", StallM, 1'b0);
        check("rst_req", bus_req, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_stall", StallM, 1'b0);
        end
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic wr, rd;
            logic [2:0] f3;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = wr ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
            do_access(rd, wr, f3, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
